// File: rtl/bs_comp_pkg.sv
// rtl/bs_comp_pkg.sv - shared types and helpers for the bs_comp magnitude comparator
//
// Contents:
//   BS_COMP_DEFAULT_WIDTH  default operand width (4)
//   cmp_res_t              encoded compare outcome {CMP_LT, CMP_EQ, CMP_GT}
//   cmp_to_flags()         cmp_res_t -> {lt, eq, gt} one-hot triple
package bs_comp_pkg;

  localparam int BS_COMP_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_t;

  // Bit order of the returned vector is {lt, eq, gt}.
  function automatic logic [2:0] cmp_to_flags(input cmp_res_t res);
    logic [2:0] flags;
    flags = 3'b000;
    case (res)
      CMP_LT:  flags = 3'b100;
      CMP_EQ:  flags = 3'b010;
      CMP_GT:  flags = 3'b001;
      default: flags = 3'b000;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/bs_comp_bit.sv
// rtl/bs_comp_bit.sv - one-bit slice of the MSB-first magnitude compare chain
//
// Ports:
//   a_i, b_i      operand bits at this position
//   up_decided    a more significant bit already differed
//   up_gt         valid when up_decided: 1 = a > b, 0 = a < b
//   dn_decided    decision state passed to the next less significant slice
//   dn_gt         direction passed to the next less significant slice
//
// Once a higher slice has decided, this slice only forwards that decision;
// otherwise the first differing bit here decides, with a=1 meaning a > b.
module bs_comp_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic up_decided,
  input  logic up_gt,
  output logic dn_decided,
  output logic dn_gt
);

  assign dn_decided = up_decided | (a_i ^ b_i);
  assign dn_gt      = up_decided ? up_gt : (a_i & ~b_i);

endmodule

// File: rtl/bs_comp4.sv
// rtl/bs_comp4.sv - registered WIDTH-bit magnitude comparator with one-hot LT/EQ/GT
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset, clears all outputs
//   a, b       WIDTH-bit operands
//   in_valid   qualifies a/b for sampling on the next rising edge
//   LT/EQ/GT   registered one-hot compare result (all 0 until first sample)
//   out_valid  1 for the cycle after a sampled pair; flags otherwise hold
//
// Build option:
//   BS_COMP4_SIGNED_EN  treat a and b as two's-complement (default: unsigned)
module bs_comp4
  import bs_comp_pkg::*;
#(
  parameter int WIDTH = BS_COMP_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             LT,
  output logic             EQ,
  output logic             GT,
  output logic             out_valid
);

  // Chain node k carries the decision after examining bits WIDTH-1 .. k.
  // Node WIDTH is the undecided seed at the top of the chain.
  logic [WIDTH:0] dec_chain;
  logic [WIDTH:0] gt_chain;

  assign dec_chain[WIDTH] = 1'b0;
  assign gt_chain[WIDTH]  = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    bs_comp_bit u_bit (
      .a_i        (a[i]),
      .b_i        (b[i]),
      .up_decided (dec_chain[i+1]),
      .up_gt      (gt_chain[i+1]),
      .dn_decided (dec_chain[i]),
      .dn_gt      (gt_chain[i])
    );
  end

  cmp_res_t chain_res;
  cmp_res_t cmp_res;

  always_comb begin
    chain_res = CMP_EQ;
    if (dec_chain[0]) begin
      chain_res = gt_chain[0] ? CMP_GT : CMP_LT;
    end
  end

`ifdef BS_COMP4_SIGNED_EN
  // When the sign bits differ the negative operand is smaller regardless of
  // the magnitude bits. When they match, the chain's MSB slice sees no
  // difference and the lower bits compare exactly as in unsigned mode.
  always_comb begin
    cmp_res = chain_res;
    if (a[WIDTH-1] != b[WIDTH-1]) begin
      cmp_res = a[WIDTH-1] ? CMP_LT : CMP_GT;
    end
  end
`else
  always_comb begin
    cmp_res = chain_res;
  end
`endif

  logic [2:0] next_flags;
  assign next_flags = cmp_to_flags(cmp_res);

  // Flags only change on a sampled pair; out_valid marks the cycle that
  // follows a sample, so flags persist with out_valid low when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LT        <= 1'b0;
      EQ        <= 1'b0;
      GT        <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      LT        <= next_flags[2];
      EQ        <= next_flags[1];
      GT        <= next_flags[0];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bs_comp4.sv
// tb/tb_bs_comp4.sv - directed self-checking bench for bs_comp4 (unsigned or BS_COMP4_SIGNED_EN build)
module tb_bs_comp4;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_valid;
  logic       LT;
  logic       EQ;
  logic       GT;
  logic       out_valid;

  int compared;
  int mismatched;

  // Expected {out_valid, LT, EQ, GT}
  localparam logic [3:0] R_NONE = 4'b0000;
  localparam logic [3:0] R_LT   = 4'b1100;
  localparam logic [3:0] R_EQ   = 4'b1010;
  localparam logic [3:0] R_GT   = 4'b1001;
  localparam logic [3:0] H_EQ   = 4'b0010;

`ifdef BS_COMP4_SIGNED_EN
  localparam logic [3:0] X_1010_0100 = R_LT;  // -6 vs 4
  localparam logic [3:0] X_0010_1100 = R_GT;  //  2 vs -4
  localparam logic [3:0] X_1111_0000 = R_LT;  // -1 vs 0
  localparam logic [3:0] X_0111_1000 = R_GT;  //  7 vs -8
`else
  localparam logic [3:0] X_1010_0100 = R_GT;  // 10 vs 4
  localparam logic [3:0] X_0010_1100 = R_LT;  //  2 vs 12
  localparam logic [3:0] X_1111_0000 = R_GT;  // 15 vs 0
  localparam logic [3:0] X_0111_1000 = R_LT;  //  7 vs 8
`endif
  localparam logic [3:0] X_1111_1000 = R_GT;  // 15 vs 8 / -1 vs -8

  bs_comp4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .LT        (LT),
    .EQ        (EQ),
    .GT        (GT),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {out_valid, LT, EQ, GT};
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed {ov,lt,eq,gt}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, return at the
  // next falling edge where outputs are stable.
  task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic v);
    a = av;
    b = bv;
    in_valid = v;
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    a          = 4'b0000;
    b          = 4'b0000;
    in_valid   = 1'b0;

    repeat (2) @(negedge clk);
    check("reset", R_NONE);

    rst_n = 1'b1;
    step(4'b0000, 4'b0000, 1'b0);
    check("release_idle", R_NONE);

    step(4'b1010, 4'b0100, 1'b1);
    check("core_1010_0100", X_1010_0100);
    step(4'b0010, 4'b1100, 1'b1);
    check("core_0010_1100", X_0010_1100);
    step(4'b1110, 4'b1110, 1'b1);
    check("core_eq_1110", R_EQ);

    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 4'b1111, 1'b0);
      check($sformatf("hold_%0d", i), H_EQ);
    end

    step(4'b1111, 4'b0000, 1'b1);
    check("ext_1111_0000", X_1111_0000);
    step(4'b0000, 4'b0000, 1'b1);
    check("ext_zero_eq", R_EQ);
    step(4'b0111, 4'b1000, 1'b1);
    check("ext_0111_1000", X_0111_1000);
    step(4'b1111, 4'b1000, 1'b1);
    check("ext_1111_1000", X_1111_1000);

    // Load a result, then pulse reset between edges with a valid pair applied.
    step(4'b1010, 4'b0100, 1'b1);
    check("pre_reset", X_1010_0100);
    a = 4'b1010;
    b = 4'b0100;
    in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("async_clear", R_NONE);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_release_no_sample", R_NONE);

    // Reset held across an edge with in_valid=1 discards the sample.
    rst_n = 1'b0;
    step(4'b1010, 4'b0100, 1'b1);
    check("reset_over_edge", R_NONE);
    rst_n = 1'b1;
    step(4'b1010, 4'b0100, 1'b1);
    check("resample", X_1010_0100);
    step(4'b0101, 4'b0101, 1'b0);
    check("resample_hold", {1'b0, X_1010_0100[2:0]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bs_comp4.md
Name: bs_comp4

Overview:
- Registered WIDTH-bit (default 4) magnitude comparator of two operands a and b.
- Produces one-hot LT/EQ/GT flags, one clock after a qualified input sample.
- Datapath is a structural chain of 1-bit compare slices, evaluated MSB-first.
- Used as a leaf compare unit wherever a registered a-vs-b decision is needed.

Parameters:
- WIDTH, 4, operand width in bits; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- LT  output  1  registered flag: a < b.
- EQ  output  1  registered flag: a == b.
- GT  output  1  registered flag: a > b.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a/b for sampling this cycle.
- out_valid  output  1  LT/EQ/GT hold a result from a sampled operand pair.

Behaviour:
- Reset: rst_n low forces LT=0, EQ=0, GT=0, out_valid=0 immediately, with no clock required. Release takes effect at the first rising clk edge with rst_n high.
- Compare function is combinational:
  - default is unsigned comparison;
  - scan from bit WIDTH-1 down to bit 0;
  - the first differing bit decides (a bit 1 means GT, b bit 1 means LT);
  - no difference at any bit means EQ.
- Registered stage: on a rising clk edge with in_valid=1, the LT/EQ/GT flags load the compare result and out_valid becomes 1.
  - Latency is exactly 1 cycle.
  - Throughput is one result per cycle.
- Hold: on a rising clk edge with in_valid=0, LT/EQ/GT hold their previous values and out_valid becomes 0. Results are never cleared except by reset.
- One-hot rule: whenever out_valid=1, exactly one of LT/EQ/GT is 1. After reset and before the first sample, all three flags are 0.
- Boundaries:
  - a=b=0 gives EQ.
  - a=all-ones, b=0 gives GT.
  - A change to a/b while in_valid=0 has no effect on the outputs.
- Reset mid-operation: asserting rst_n during any cycle, including a cycle with in_valid=1, clears all outputs. That sample is discarded.
- No X propagation: the outputs are fully defined from reset onward.

Optional Feature:
- Macro: BS_COMP4_SIGNED_EN.
- When defined: a and b are treated as two's-complement.
  - Sign bits differ: the operand with sign bit 1 is smaller.
  - Sign bits equal: the remaining bits compare as in unsigned mode.
- When not defined: unsigned comparison only.
- Ports, latency and reset behaviour are identical in both builds.

Decomposition:
- Package bs_comp_pkg holds:
  - localparam default width (4);
  - a result-encoding enum cmp_res_t {CMP_LT, CMP_EQ, CMP_GT};
  - a function converting cmp_res_t to the {LT, EQ, GT} one-hot triple.
- Sub-module bs_comp_bit: 1-bit slice.
  - Inputs: a_i, b_i and the upstream decision (decided, lt/gt).
  - Output: the downstream decision.
  - WIDTH instances are chained MSB to LSB through a generate loop.
- The top level adds the signed-mode sign-bit override, the output registers and out_valid.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> LT=EQ=GT=0 and out_valid=0. Deassert with in_valid=0 -> outputs stay 0.
- Core vectors, each with in_valid=1 and checked one cycle later:
  - a=4'b1010, b=4'b0100 -> GT=1, LT=0, EQ=0, out_valid=1;
  - a=4'b0010, b=4'b1100 -> LT=1;
  - a=4'b1110, b=4'b1110 -> EQ=1.
- Hold: after the EQ result, set in_valid=0 and a=0, b=4'b1111 for 3 cycles -> EQ stays 1 and out_valid=0.
- Extremes: a=4'b1111, b=0 -> GT; a=0, b=0 -> EQ; a=4'b0111, b=4'b1000 -> LT (unsigned build).
- Async reset mid-stream: drive a=4'b1010, b=4'b0100 with in_valid=1 and pulse rst_n low between clock edges -> outputs clear at once, and the next edge after release does not show GT unless the pair is resampled.
- Signed build (BS_COMP4_SIGNED_EN defined):
  - a=4'b1010 (-6), b=4'b0100 (4) -> LT;
  - a=4'b1111 (-1), b=4'b1000 (-8) -> GT;
  - a=4'b0111, b=4'b1000 -> GT.
